// File: rtl/tzc_pkg.sv
// rtl/tzc_pkg.sv - shared types and helpers for the trailing-zero count / bitmap blocks
package tzc_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } asm_state_t;

    function automatic int cnt_w(input int data_width);
        return $clog2(data_width) + 1;
    endfunction

endpackage

// File: rtl/tzc_onehot_dec.sv
// rtl/tzc_onehot_dec.sv - bit index to one-hot decoder with range check
module tzc_onehot_dec
    import tzc_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    localparam int CNT_W      = cnt_w(DATA_WIDTH)
) (
    input  logic [CNT_W-1:0]      i_cnt,
    output logic [DATA_WIDTH-1:0] o_onehot,
    output logic                  o_in_range
);

    // Index DATA_WIDTH is the legal "no bit" marker: no bit set, but still in range.
    always_comb begin
        o_onehot   = '0;
        o_in_range = (i_cnt <= CNT_W'(DATA_WIDTH));
        if (i_cnt < CNT_W'(DATA_WIDTH)) begin
            o_onehot = DATA_WIDTH'(1) << i_cnt;
        end
    end

endmodule

// File: rtl/tzc_bitmap_assembler.sv
// rtl/tzc_bitmap_assembler.sv - rebuilds a bitmap from a stream of bit indices
module tzc_bitmap_assembler
    import tzc_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    localparam int CNT_W      = cnt_w(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CNT_W-1:0]      in_cnt,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]      out_count,
    output logic                  out_dup,
    output logic                  out_range
);

    asm_state_t            r_state;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]      r_count;
    logic                  r_dup;
    logic                  r_range;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [CNT_W-1:0]      r_out_count;
    logic                  r_out_dup;
    logic                  r_out_range;

    logic [DATA_WIDTH-1:0] w_onehot;
    logic                  w_in_range;
    logic                  w_accept;
    logic                  w_hit;
    logic                  w_inc;
    logic [DATA_WIDTH-1:0] w_acc_nxt;
    logic [CNT_W-1:0]      w_count_nxt;
    logic                  w_dup_nxt;
    logic                  w_range_nxt;

    tzc_onehot_dec #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_dec (
        .i_cnt      (in_cnt),
        .o_onehot   (w_onehot),
        .o_in_range (w_in_range)
    );

    // Handshake signals decode the registered state only, so out_ready never reaches in_ready.
    assign in_ready  = (r_state == ACCUM);
    assign out_valid = (r_state == HOLD);
    assign w_accept  = in_valid & in_ready;

    // A repeated index flags dup and leaves the count alone, which caps count at DATA_WIDTH.
    assign w_hit       = |(r_acc & w_onehot);
    assign w_inc       = (|w_onehot) & ~w_hit;
    assign w_acc_nxt   = r_acc | w_onehot;
    assign w_count_nxt = r_count + CNT_W'(w_inc);
    assign w_dup_nxt   = r_dup | w_hit;
    assign w_range_nxt = r_range | ~w_in_range;

    assign out_data  = r_out_data;
    assign out_count = r_out_count;
    assign out_dup   = r_out_dup;
    assign out_range = r_out_range;

    // Accumulate beats, publish the frame on the last beat, then hold until it is taken.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ACCUM;
            r_acc       <= '0;
            r_count     <= '0;
            r_dup       <= 1'b0;
            r_range     <= 1'b0;
            r_out_data  <= '0;
            r_out_count <= '0;
            r_out_dup   <= 1'b0;
            r_out_range <= 1'b0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (w_accept) begin
                        if (in_last) begin
                            r_out_data  <= w_acc_nxt;
                            r_out_count <= w_count_nxt;
                            r_out_dup   <= w_dup_nxt;
                            r_out_range <= w_range_nxt;
                            r_acc       <= '0;
                            r_count     <= '0;
                            r_dup       <= 1'b0;
                            r_range     <= 1'b0;
                            r_state     <= HOLD;
                        end else begin
                            r_acc   <= w_acc_nxt;
                            r_count <= w_count_nxt;
                            r_dup   <= w_dup_nxt;
                            r_range <= w_range_nxt;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_state <= ACCUM;
                    end
                end
                default: r_state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_tzc_bitmap_assembler.sv
// tb/tb_tzc_bitmap_assembler.sv - directed table-driven bench for tzc_bitmap_assembler
module tb_tzc_bitmap_assembler;

    localparam int DW = 32;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] in_cnt = '0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_count;
    logic          out_dup;
    logic          out_range;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int                   n;
        logic [2:0][CW-1:0]   cnts;
        logic [DW-1:0]        exp_data;
        logic [CW-1:0]        exp_count;
        logic                 exp_dup;
        logic                 exp_range;
        int                   exp_tz;
    } vec_t;

    vec_t vecs[8];

    tzc_bitmap_assembler #(.DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_cnt    (in_cnt),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_dup   (out_dup),
        .out_range (out_range)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input int n, input logic [CW-1:0] c0, input logic [CW-1:0] c1,
                                input logic [CW-1:0] c2, input logic [DW-1:0] d,
                                input logic [CW-1:0] cnt, input logic dup, input logic rng,
                                input int tz);
        vec_t v;
        v.n = n;
        v.cnts[0] = c0;
        v.cnts[1] = c1;
        v.cnts[2] = c2;
        v.exp_data = d;
        v.exp_count = cnt;
        v.exp_dup = dup;
        v.exp_range = rng;
        v.exp_tz = tz;
        return v;
    endfunction

    function automatic int ctz(input logic [DW-1:0] d);
        for (int i = 0; i < DW; i++) begin
            if (d[i]) return i;
        end
        return DW;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives the beats of one frame at negedges; returns at the negedge after the last beat edge.
    task automatic send_beats(input int n, input logic [2:0][CW-1:0] c, input logic last_on_final);
        for (int b = 0; b < n; b++) begin
            @(negedge clk);
            chk("in_ready_accum", in_ready, 1);
            chk("out_valid_accum", out_valid, 0);
            in_valid = 1'b1;
            in_cnt   = c[b];
            in_last  = last_on_final && (b == n - 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_word(input string tag, input logic [DW-1:0] d, input logic [CW-1:0] cnt,
                              input logic dup, input logic rng);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_data"}, out_data, d);
        chk({tag, "_count"}, out_count, cnt);
        chk({tag, "_dup"}, out_dup, dup);
        chk({tag, "_range"}, out_range, rng);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_hs_valid", out_valid, 0);
        chk("post_hs_in_ready", in_ready, 1);
    endtask

    initial begin
        vecs[0] = mk(1,  5,  0,  0, 32'h0000_0020, 1, 0, 0, 5);
        vecs[1] = mk(3,  0,  3, 31, 32'h8000_0009, 3, 0, 0, 0);
        vecs[2] = mk(1, 32,  0,  0, 32'h0000_0000, 0, 0, 0, 32);
        vecs[3] = mk(1, 40,  0,  0, 32'h0000_0000, 0, 0, 1, 32);
        vecs[4] = mk(2,  7,  7,  0, 32'h0000_0080, 1, 1, 0, 7);
        vecs[5] = mk(3, 33,  1, 32, 32'h0000_0002, 1, 0, 1, 1);
        vecs[6] = mk(3, 31, 31, 31, 32'h8000_0000, 1, 1, 0, 31);
        vecs[7] = mk(1,  0,  0,  0, 32'h0000_0001, 1, 0, 0, 0);

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_data", out_data, 0);
        chk("rst_count", out_count, 0);
        chk("rst_dup", out_dup, 0);
        chk("rst_range", out_range, 0);
        resetn = 1'b1;

        // Table of frames
        for (int v = 0; v < 8; v++) begin
            send_beats(vecs[v].n, vecs[v].cnts, 1'b1);
            check_word($sformatf("vec%0d", v), vecs[v].exp_data, vecs[v].exp_count,
                       vecs[v].exp_dup, vecs[v].exp_range);
            chk($sformatf("vec%0d_loopback_tz", v), ctz(out_data), vecs[v].exp_tz);
            handshake();
        end

        // Backpressure: word held for 5 cycles, beats offered meanwhile are ignored
        send_beats(1, {6'd0, 6'd0, 6'd2}, 1'b1);
        in_valid = 1'b1;
        in_cnt   = 6'd9;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_word("hold", 32'h4, 1, 0, 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        handshake();
        chk("hold_data_kept", out_data, 32'h4);
        send_beats(1, {6'd0, 6'd0, 6'd3}, 1'b1);
        check_word("after_hold", 32'h8, 1, 0, 0);

        // Reset while a word is pending
        #2 resetn = 1'b0;
        #1;
        chk("rst_hold_valid", out_valid, 0);
        chk("rst_hold_data", out_data, 0);
        chk("rst_hold_in_ready", in_ready, 1);
        @(negedge clk);
        resetn = 1'b1;

        // Reset mid-frame discards the partial accumulation
        send_beats(2, {6'd0, 6'd4, 6'd2}, 1'b0);
        #2 resetn = 1'b0;
        #1;
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_count", out_count, 0);
        @(negedge clk);
        resetn = 1'b1;
        send_beats(1, {6'd0, 6'd0, 6'd1}, 1'b1);
        check_word("after_rst", 32'h2, 1, 0, 0);
        handshake();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
